pred_sse16x16: RTL



---
 rtl/vp8_enc_pkg.sv | 21 ++
 rtl/pred_sse16x16_row_sq_diff_sum.sv | 33 +++
 rtl/pred_sse16x16.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vp8_enc_pkg.sv
// Shared encoder constants: pixel/block defaults, SSE FSM state encoding, row-sum width.
package vp8_enc_pkg;

  localparam int unsigned BIT_WIDTH_DEF  = 8;
  localparam int unsigned BLOCK_SIZE_DEF = 16;
  localparam int unsigned SSE_WIDTH_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sse_state_e;

  function automatic int unsigned row_sum_width(input int unsigned bw, input int unsigned bs);
    return 2 * bw + $clog2(bs);
  endfunction

  localparam int unsigned ROW_SUM_W_DEF = row_sum_width(BIT_WIDTH_DEF, BLOCK_SIZE_DEF);

endpackage

// File: rtl/pred_sse16x16_row_sq_diff_sum.sv
// Combinational sum of squared differences over one row of BLOCK_SIZE pixels.
module row_sq_diff_sum
  import vp8_enc_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int unsigned ROW_SUM_W  = row_sum_width(BIT_WIDTH, BLOCK_SIZE)
) (
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] src_row,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] pred_row,
  output logic [ROW_SUM_W-1:0]            row_sum
);

  logic signed [BIT_WIDTH:0]   diff;
  logic        [BIT_WIDTH:0]   mag;
  logic        [2*BIT_WIDTH-1:0] sq;

  always_comb begin
    row_sum = '0;
    diff    = '0;
    mag     = '0;
    sq      = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
      diff = $signed({1'b0, src_row[i*BIT_WIDTH +: BIT_WIDTH]})
           - $signed({1'b0, pred_row[i*BIT_WIDTH +: BIT_WIDTH]});
      // |diff| never exceeds 2^BIT_WIDTH-1, so the low BIT_WIDTH bits hold it exactly
      mag     = diff[BIT_WIDTH] ? (BIT_WIDTH+1)'(-diff) : (BIT_WIDTH+1)'(diff);
      sq      = (2*BIT_WIDTH)'(mag[BIT_WIDTH-1:0]) * (2*BIT_WIDTH)'(mag[BIT_WIDTH-1:0]);
      row_sum = row_sum + ROW_SUM_W'(sq);
    end
  end

endmodule

// File: rtl/pred_sse16x16.sv
// Multicycle block SSE: one row per cycle through a shared row_sq_diff_sum.
// Define VP8_SSE_PIPE_EN to register the row sum before the accumulator (adds a DRAIN cycle).
module pred_sse16x16
  import vp8_enc_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int unsigned BLOCK_SIZE = BLOCK_SIZE_DEF,
  parameter int unsigned SSE_WIDTH  = SSE_WIDTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] src,
  output logic                                    busy,
  output logic                                    done,
  output logic [SSE_WIDTH-1:0]                    sse
);

  localparam int unsigned ROW_W    = row_sum_width(BIT_WIDTH, BLOCK_SIZE);
  localparam int unsigned ROW_BITS = BIT_WIDTH * BLOCK_SIZE;
  localparam int unsigned CNT_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  sse_state_e           state_q, state_d;
  logic [CNT_W-1:0]     row_q, row_d;
  logic [SSE_WIDTH-1:0] acc_q, acc_d;
  logic [SSE_WIDTH-1:0] sse_q, sse_d;
  logic                 done_q, done_d;

  logic [ROW_BITS-1:0]  src_row, pred_row;
  logic [ROW_W-1:0]     row_sum, add_term;
  logic                 last_row, accept;

  always_comb begin
    src_row  = src[int'(row_q)*ROW_BITS +: ROW_BITS];
    pred_row = pred[int'(row_q)*ROW_BITS +: ROW_BITS];
  end

  row_sq_diff_sum #(
    .BIT_WIDTH (BIT_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE),
    .ROW_SUM_W (ROW_W)
  ) u_row (
    .src_row (src_row),
    .pred_row(pred_row),
    .row_sum (row_sum)
  );

  assign last_row = (row_q == CNT_W'(BLOCK_SIZE - 1));
  // The done pulse falls in an IDLE cycle, but start is still ignored there
  assign accept   = (state_q == IDLE) && start && !done_q;

`ifdef VP8_SSE_PIPE_EN
  logic [ROW_W-1:0] rs_q, rs_d;

  always_comb begin
    rs_d     = (state_q == RUN) ? row_sum : '0;
    add_term = rs_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rs_q <= '0;
    else        rs_q <= rs_d;
  end
`else
  assign add_term = row_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      acc_q   <= '0;
      sse_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      sse_q   <= sse_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = RUN;
`ifdef VP8_SSE_PIPE_EN
      RUN:   if (last_row) state_d = DRAIN;
      DRAIN: state_d = DONE;
`else
      RUN:   if (last_row) state_d = DONE;
      DRAIN: state_d = IDLE;
`endif
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d  = row_q;
    acc_d  = acc_q;
    sse_d  = sse_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        row_d = '0;
        acc_d = '0;
      end
      RUN: begin
        acc_d = acc_q + SSE_WIDTH'(add_term);
        row_d = row_q + 1'b1;
      end
      DRAIN: acc_d = acc_q + SSE_WIDTH'(add_term);
      DONE: begin
        sse_d  = acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE) || done_q;
    done = done_q;
    sse  = sse_q;
  end

endmodule
